l2_mem_bridge: RTL and testbench

Sits directly downstream of the L2 cache and consumes its line-level memory requests: L2 read miss fills and dirty-line write-backs. Converts each 512-bit line transfer into a burst of narrow beats on a command/data handshake bus toward the main-memory controller. Returns the assembled fill line and a one-cycle ready pulse to L2. One transaction in flight; an eviction plus fill pair is serviced as write-back then read, with a single ready at the end.

---
 rtl/l2_mem_bridge_if.sv | 31 +++
 rtl/l2_mem_bridge.sv | 168 ++++++++++++++++
 tb/tb_l2_mem_bridge.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_mem_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : l2_mem_bridge_if
// Brief    : Command/write/read beat bus between the L2 bridge and memory.
// Revision : 1.0 - initial release
// ============================================================================
interface l2_mem_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int BEAT_W = 64
);
    logic              mem_cmd_valid;
    logic              mem_cmd_ready;
    logic              mem_cmd_we;
    logic [ADDR_W-1:0] mem_cmd_addr;
    logic              mem_wvalid;
    logic              mem_wready;
    logic [BEAT_W-1:0] mem_wdata;
    logic              mem_rvalid;
    logic [BEAT_W-1:0] mem_rdata;

    modport master (
        output mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_wvalid, mem_wdata,
        input  mem_cmd_ready, mem_wready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_wvalid, mem_wdata,
        output mem_cmd_ready, mem_wready, mem_rvalid, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/l2_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : l2_mem_bridge
// Brief    : Splits L2 line fills / write-backs into narrow memory bursts.
// Revision : 1.0 - initial release
// ============================================================================
module l2_mem_bridge #(
    parameter int LINE_W = 512,
    parameter int BEAT_W = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_L2_MEM,
    input  logic              write_L2_MEM,
    input  logic [7:0]        index_L2_MEM,
    input  logic [17:0]       tag_L2_MEM,
    input  logic [17:0]       write_tag_L2_MEM,
    input  logic [LINE_W-1:0] write_data_L2_MEM,
    output logic [LINE_W-1:0] read_data_MEM_L2,
    output logic              ready_MEM_L2,
    output logic              busy,
    l2_mem_bridge_if.master   mem
);
    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WCMD  = 3'd1,
        S_WDATA = 3'd2,
        S_RCMD  = 3'd3,
        S_RDATA = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [7:0]          index_q;
    logic [17:0]         tag_q;
    logic [17:0]         wtag_q;
    logic [LINE_W-1:0]   wline_q;
    logic                rd_flag_q;
    logic [BEAT_W-1:0]   fill_q [BEATS];

    logic                w_latch;
    logic                w_fill_we;
    logic                w_cmd_valid;
    logic                w_cmd_we;
    logic [ADDR_W-1:0]   w_cmd_addr;
    logic                w_wvalid;
    logic [BEAT_W-1:0]   w_wdata;
    logic [ADDR_W-1:0]   w_waddr;
    logic [ADDR_W-1:0]   w_raddr;
    logic [BEAT_W-1:0]   w_wbeat [BEATS];

    assign w_waddr = ADDR_W'({wtag_q, index_q, {OFF_W{1'b0}}});
    assign w_raddr = ADDR_W'({tag_q,  index_q, {OFF_W{1'b0}}});

    // Beat 0 is the least-significant slice of the line in both directions.
    for (genvar b = 0; b < BEATS; b++) begin : g_beats
        assign w_wbeat[b] = wline_q[b*BEAT_W +: BEAT_W];
        assign read_data_MEM_L2[b*BEAT_W +: BEAT_W] = fill_q[b];
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        w_latch      = 1'b0;
        w_fill_we    = 1'b0;
        w_cmd_valid  = 1'b0;
        w_cmd_we     = 1'b0;
        w_cmd_addr   = '0;
        w_wvalid     = 1'b0;
        w_wdata      = '0;
        ready_MEM_L2 = 1'b0;
        busy         = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (read_L2_MEM || write_L2_MEM) begin
                    w_latch = 1'b1;
                    state_d = write_L2_MEM ? S_WCMD : S_RCMD;
                end
            end
            S_WCMD: begin
                w_cmd_valid = 1'b1;
                w_cmd_we    = 1'b1;
                w_cmd_addr  = w_waddr;
                if (mem.mem_cmd_ready) begin
                    cnt_d   = '0;
                    state_d = S_WDATA;
                end
            end
            S_WDATA: begin
                w_wvalid = 1'b1;
                w_wdata  = w_wbeat[cnt_q];
                if (mem.mem_wready) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = rd_flag_q ? S_RCMD : S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_RCMD: begin
                w_cmd_valid = 1'b1;
                w_cmd_addr  = w_raddr;
                if (mem.mem_cmd_ready) begin
                    cnt_d   = '0;
                    state_d = S_RDATA;
                end
            end
            S_RDATA: begin
                if (mem.mem_rvalid) begin
                    w_fill_we = 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                ready_MEM_L2 = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            index_q   <= '0;
            tag_q     <= '0;
            wtag_q    <= '0;
            wline_q   <= '0;
            rd_flag_q <= 1'b0;
            for (int b = 0; b < BEATS; b++) begin
                fill_q[b] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_latch) begin
                index_q   <= index_L2_MEM;
                tag_q     <= tag_L2_MEM;
                wtag_q    <= write_tag_L2_MEM;
                wline_q   <= write_data_L2_MEM;
                rd_flag_q <= read_L2_MEM;
            end
            if (w_fill_we) begin
                fill_q[cnt_q] <= mem.mem_rdata;
            end
        end
    end

    assign mem.mem_cmd_valid = w_cmd_valid;
    assign mem.mem_cmd_we    = w_cmd_we;
    assign mem.mem_cmd_addr  = w_cmd_addr;
    assign mem.mem_wvalid    = w_wvalid;
    assign mem.mem_wdata     = w_wdata;
endmodule
`default_nettype wire

// File: tb/tb_l2_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_mem_bridge
// Brief    : Directed vector bench for l2_mem_bridge with a scripted memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l2_mem_bridge;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         read_L2_MEM = 1'b0;
    logic         write_L2_MEM = 1'b0;
    logic [7:0]   index_L2_MEM = '0;
    logic [17:0]  tag_L2_MEM = '0;
    logic [17:0]  write_tag_L2_MEM = '0;
    logic [511:0] write_data_L2_MEM = '0;
    logic [511:0] read_data_MEM_L2;
    logic         ready_MEM_L2;
    logic         busy;

    l2_mem_bridge_if #(.ADDR_W(32), .BEAT_W(64)) mem_if ();

    l2_mem_bridge #(.LINE_W(512), .BEAT_W(64), .ADDR_W(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .read_L2_MEM       (read_L2_MEM),
        .write_L2_MEM      (write_L2_MEM),
        .index_L2_MEM      (index_L2_MEM),
        .tag_L2_MEM        (tag_L2_MEM),
        .write_tag_L2_MEM  (write_tag_L2_MEM),
        .write_data_L2_MEM (write_data_L2_MEM),
        .read_data_MEM_L2  (read_data_MEM_L2),
        .ready_MEM_L2      (ready_MEM_L2),
        .busy              (busy),
        .mem               (mem_if.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- scripted memory ----------------
    int          cfg_delay = 0;
    bit          cfg_wtoggle = 0, cfg_rgap = 0, cfg_spur = 0;
    logic [63:0] cfg_rbase = '0;

    logic [31:0] cmd_addr_q [$];
    logic        cmd_we_q   [$];
    int          cmd_cyc_q  [$];
    logic [63:0] wbeat_q    [$];
    int          wbeat_last_cyc = 0;
    int          ready_cnt = 0;
    int          rbeat = 0;

    initial begin
        bit          rd_active = 0;
        int          rp = 0, wcyc = 0, wait_cnt = 0;
        bit          prev_cv = 0, prev_cr = 0, prev_wv = 0, prev_wr = 0;
        logic [32:0] prev_cmd = '0;
        logic [63:0] prev_wd = '0;
        mem_if.mem_cmd_ready = 0;
        mem_if.mem_wready    = 0;
        mem_if.mem_rvalid    = 0;
        mem_if.mem_rdata     = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                rd_active = 0; wait_cnt = 0; wcyc = 0;
                prev_cv = 0; prev_wv = 0;
                mem_if.mem_cmd_ready = 0;
                mem_if.mem_wready    = 0;
                mem_if.mem_rvalid    = 0;
            end else begin
                if (prev_cv && !prev_cr)
                    chk("cmd_stable", {mem_if.mem_cmd_valid, mem_if.mem_cmd_we, mem_if.mem_cmd_addr},
                        {1'b1, prev_cmd});
                if (prev_wv && !prev_wr)
                    chk("wdata_stable", {mem_if.mem_wvalid, mem_if.mem_wdata}, {1'b1, prev_wd});
                if (ready_MEM_L2) ready_cnt++;

                if (rd_active) begin
                    if (!cfg_rgap || (rp % 3 == 0)) begin
                        mem_if.mem_rvalid = 1;
                        mem_if.mem_rdata  = cfg_rbase + 64'(rbeat);
                        rbeat++;
                        if (rbeat == 8) rd_active = 0;
                    end else begin
                        mem_if.mem_rvalid = 0;
                    end
                    rp++;
                end else if (cfg_spur) begin
                    mem_if.mem_rvalid = 1;
                    mem_if.mem_rdata  = 64'hDEAD_BEEF_0BAD_F00D;
                end else begin
                    mem_if.mem_rvalid = 0;
                end

                if (mem_if.mem_cmd_valid) begin
                    if (wait_cnt >= cfg_delay) begin
                        mem_if.mem_cmd_ready = 1;
                        cmd_addr_q.push_back(mem_if.mem_cmd_addr);
                        cmd_we_q.push_back(mem_if.mem_cmd_we);
                        cmd_cyc_q.push_back(cyc);
                        if (!mem_if.mem_cmd_we) begin
                            rd_active = 1; rbeat = 0; rp = 0;
                        end
                        wait_cnt = 0;
                    end else begin
                        mem_if.mem_cmd_ready = 0;
                        wait_cnt++;
                    end
                end else begin
                    mem_if.mem_cmd_ready = 0;
                    wait_cnt = 0;
                end

                if (mem_if.mem_wvalid) begin
                    mem_if.mem_wready = !cfg_wtoggle || (wcyc % 2 == 0);
                    if (mem_if.mem_wready) begin
                        wbeat_q.push_back(mem_if.mem_wdata);
                        wbeat_last_cyc = cyc;
                    end
                    wcyc++;
                end else begin
                    mem_if.mem_wready = 0;
                    wcyc = 0;
                end

                prev_cv  = mem_if.mem_cmd_valid;
                prev_cr  = mem_if.mem_cmd_ready;
                prev_cmd = {mem_if.mem_cmd_we, mem_if.mem_cmd_addr};
                prev_wv  = mem_if.mem_wvalid;
                prev_wr  = mem_if.mem_wready;
                prev_wd  = mem_if.mem_wdata;
            end
        end
    end

    // ---------------- vectors ----------------
    typedef struct {
        bit          rd, wr;
        logic [17:0] tag, wtag;
        logic [7:0]  idx;
        int          cmd_delay;
        bit          wtoggle, rgap, spur;
        logic [7:0]  seed;
        logic [63:0] rbase;
        int          exp_lat;
        logic [31:0] exp_waddr, exp_raddr;
    } vec_t;

    vec_t         vecs [6];
    logic [511:0] exp_fill = '0;
    int           req_cyc = 0;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive_req(input vec_t v);
        logic [511:0] line;
        for (int i = 0; i < 64; i++) line[i*8 +: 8] = v.seed + 8'(i);
        cfg_delay = v.cmd_delay; cfg_wtoggle = v.wtoggle; cfg_rgap = v.rgap;
        cfg_spur = v.spur; cfg_rbase = v.rbase;
        read_L2_MEM = v.rd; write_L2_MEM = v.wr;
        tag_L2_MEM = v.tag; write_tag_L2_MEM = v.wtag;
        index_L2_MEM = v.idx; write_data_L2_MEM = line;
        req_cyc = cyc;
    endtask

    task automatic wait_ready(input string nm, input int exp_lat);
        int lat = -1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (ready_MEM_L2) begin
                lat = cyc - req_cyc;
                break;
            end
        end
        chk(nm, 512'(lat), 512'(exp_lat));
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        logic [511:0] line;
        int           ncmd;
        for (int i = 0; i < 64; i++) line[i*8 +: 8] = v.seed + 8'(i);
        cmd_addr_q.delete(); cmd_we_q.delete(); cmd_cyc_q.delete(); wbeat_q.delete();
        ready_cnt = 0;
        cfg_spur = v.spur;
        tick(); tick();
        chk({nm, "_idle_busy"}, 512'(busy), 512'(0));
        drive_req(v);
        wait_ready({nm, "_latency"}, v.exp_lat);
        read_L2_MEM = 0; write_L2_MEM = 0;
        tick(); tick();
        chk({nm, "_ready_count"}, 512'(ready_cnt), 512'(1));
        chk({nm, "_busy_after"}, 512'(busy), 512'(0));
        ncmd = (v.rd ? 1 : 0) + (v.wr ? 1 : 0);
        chk({nm, "_cmd_count"}, 512'(cmd_addr_q.size()), 512'(ncmd));
        if (v.wr && cmd_addr_q.size() >= 1) begin
            chk({nm, "_waddr"}, 512'(cmd_addr_q[0]), 512'(v.exp_waddr));
            chk({nm, "_wwe"}, 512'(cmd_we_q[0]), 512'(1));
            chk({nm, "_wbeats"}, 512'(wbeat_q.size()), 512'(8));
            for (int k = 0; k < 8 && k < wbeat_q.size(); k++)
                chk($sformatf("%s_wbeat%0d", nm, k), 512'(wbeat_q[k]), 512'(line[k*64 +: 64]));
        end
        if (v.rd && cmd_addr_q.size() == ncmd) begin
            chk({nm, "_raddr"}, 512'(cmd_addr_q[ncmd-1]), 512'(v.exp_raddr));
            chk({nm, "_rwe"}, 512'(cmd_we_q[ncmd-1]), 512'(0));
            if (v.wr)
                chk({nm, "_wr_before_rd"}, 512'(wbeat_last_cyc < cmd_cyc_q[1]), 512'(1));
            for (int k = 0; k < 8; k++) exp_fill[k*64 +: 64] = v.rbase + 64'(k);
        end
        chk({nm, "_fill"}, read_data_MEM_L2, exp_fill);
    endtask

    initial begin
        vec_t vr;
        bit   hit;
        //            rd wr tag        wtag       idx    dly tg gp sp seed   rbase                   lat waddr          raddr
        vecs[0] = '{1, 0, 18'h2A5F3, 18'h00000, 8'h11, 0, 0, 0, 0, 8'h00, 64'h1111_0000_0000_0000, 10, 32'h0,         32'hA97CC440};
        vecs[1] = '{0, 1, 18'h00000, 18'h00001, 8'h02, 0, 1, 0, 0, 8'h00, 64'h0,                   17, 32'h00004080,  32'h0};
        vecs[2] = '{1, 1, 18'h3FFFF, 18'h12345, 8'hFF, 3, 0, 0, 0, 8'h40, 64'h2222_0000_0000_0000, 25, 32'h48D17FC0,  32'hFFFFFFC0};
        vecs[3] = '{1, 0, 18'h00ABC, 18'h00000, 8'h40, 0, 0, 1, 1, 8'h00, 64'h3333_0000_0000_0000, 24, 32'h0,         32'h02AF1000};
        vecs[4] = '{0, 1, 18'h00000, 18'h20000, 8'h80, 0, 0, 0, 0, 8'hC0, 64'h0,                   10, 32'h80002000,  32'h0};
        vecs[5] = '{1, 1, 18'h0F0F0, 18'h00F0F, 8'h5A, 0, 0, 0, 0, 8'h80, 64'hA5A5_0000_0000_0000, 19, 32'h03C3D680,  32'h3C3C1680};

        #1;
        chk("rst_fill", read_data_MEM_L2, '0);
        chk("rst_ready", 512'(ready_MEM_L2), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_cmd", 512'({mem_if.mem_cmd_valid, mem_if.mem_cmd_we, mem_if.mem_cmd_addr}), 512'(0));
        chk("rst_wbus", 512'({mem_if.mem_wvalid, mem_if.mem_wdata}), 512'(0));
        @(posedge clk); @(posedge clk); #1;
        rst = 0;

        for (int i = 0; i < 6; i++) begin
            run_vec($sformatf("v%0d", i), vecs[i]);
            if (i == 0) begin
                chk("v0_low_beat", 512'(read_data_MEM_L2[63:0]), 512'(64'h1111000000000000));
                chk("v0_high_beat", 512'(read_data_MEM_L2[511:448]), 512'(64'h1111000000000007));
            end
            if (i == 1 && wbeat_q.size() > 0)
                chk("v1_beat0", 512'(wbeat_q[0]), 512'(64'h0706050403020100));
        end

        // Asynchronous reset in the middle of a read burst.
        vr = '{1, 0, 18'h00155, 18'h0, 8'h33, 0, 0, 0, 0, 8'h00, 64'hC0DE_0000_0000_0000, 10, 32'h0, 32'h00554CC0};
        drive_req(vr);
        hit = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #3;
            if (rbeat >= 4) begin hit = 1; break; end
        end
        chk("rstmid_reached_beat4", 512'(hit), 512'(1));
        rst = 1; read_L2_MEM = 0;
        #1;
        chk("rstmid_fill", read_data_MEM_L2, '0);
        chk("rstmid_busy", 512'(busy), 512'(0));
        chk("rstmid_outs", 512'({ready_MEM_L2, mem_if.mem_cmd_valid, mem_if.mem_wvalid}), 512'(0));
        @(posedge clk); @(posedge clk); #3;
        rst = 0;
        exp_fill = '0;
        vr.rbase = 64'h7777_0000_0000_0000;
        run_vec("post_rst", vr);

        // Request held through DONE is taken only in the following IDLE cycle.
        vr = '{1, 0, 18'h00003, 18'h0, 8'h04, 0, 0, 0, 0, 8'h00, 64'h5555_0000_0000_0000, 10, 32'h0, 32'h0000C100};
        ready_cnt = 0;
        drive_req(vr);
        wait_ready("hold_first_lat", 10);
        chk("hold_done_busy", 512'(busy), 512'(1));
        tick();
        chk("hold_no_double_ready", 512'(ready_MEM_L2), 512'(0));
        chk("hold_idle_busy", 512'(busy), 512'(0));
        req_cyc = cyc;
        tick();
        chk("hold_accepted", 512'(busy), 512'(1));
        wait_ready("hold_second_lat", 10);
        read_L2_MEM = 0;
        tick(); tick();
        chk("hold_ready_count", 512'(ready_cnt), 512'(2));
        for (int k = 0; k < 8; k++) exp_fill[k*64 +: 64] = 64'h5555_0000_0000_0000 + 64'(k);
        chk("hold_fill", read_data_MEM_L2, exp_fill);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
